// File: rtl/dmem_dp.sv
// Dual-port data memory: processor load/store port A, handshaked host port B,
// a one-word-per-cycle clear engine and a sticky out-of-range flag.
module dmem_dp #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 19,
  parameter int                DEPTH    = 67001,
  parameter logic [DATA_W-1:0] FILL_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] d_in,
  input  logic [1:0]        MEM_WRITE,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  input  logic [ADDR_W-1:0] extAddr,
  input  logic [DATA_W-1:0] ext_d_in,
  input  logic              ext_we,
  input  logic              ext_req,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_d_out,
  input  logic              clr_start,
  output logic              busy,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1   = ADDR_W + 1;
  localparam logic [AW1-1:0]   DEPTH_A  = AW1'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_dOut;
  logic              r_dValid;
  logic              r_extAck;
  logic [DATA_W-1:0] r_extDOut;
  logic              r_addrErr;

  logic              w_idle;
  logic              w_aWr;
  logic              w_aRd;
  logic              w_aOk;
  logic              w_bOk;
  logic              w_bAcc;
  logic [IDX_W-1:0]  w_aIdx;
  logic [IDX_W-1:0]  w_bIdx;

  assign w_idle = (r_state == S_IDLE);
  assign w_aWr  = w_idle && (MEM_WRITE == 2'b10);
  assign w_aRd  = w_idle && (MEM_WRITE == 2'b01);
  assign w_aOk  = ({1'b0, dAddr} < DEPTH_A);
  assign w_bOk  = ({1'b0, extAddr} < DEPTH_A);
  assign w_aIdx = dAddr[IDX_W-1:0];
  assign w_bIdx = extAddr[IDX_W-1:0];

  // Port B yields to a same-address port A write and retries next edge; it is
  // never accepted in its own ack cycle, so one held request is one transaction.
  assign w_bAcc = w_idle && ext_req && !r_extAck &&
                  !(ext_we && w_aWr && (extAddr == dAddr));

  // Storage has no reset; A and B can only both write here at distinct addresses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) r_mem[r_ptr] <= FILL_VAL;
      if (w_aWr && w_aOk) r_mem[w_aIdx] <= d_in;
      if (w_bAcc && ext_we && w_bOk) r_mem[w_bIdx] <= ext_d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_dOut    <= '0;
      r_dValid  <= 1'b0;
      r_extAck  <= 1'b0;
      r_extDOut <= '0;
      r_addrErr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr_start) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
          end
        end
        default: begin
          if (r_ptr == LAST_IDX) r_state <= S_IDLE;
          else                   r_ptr   <= r_ptr + 1'b1;
        end
      endcase

      r_dValid <= w_aRd;
      if (w_aRd) r_dOut <= w_aOk ? r_mem[w_aIdx] : '0;

      r_extAck <= w_bAcc;
      if (w_bAcc && !ext_we) r_extDOut <= w_bOk ? r_mem[w_bIdx] : '0;

      if (((w_aWr || w_aRd) && !w_aOk) || (w_bAcc && !w_bOk)) r_addrErr <= 1'b1;
    end
  end

  assign d_out     = r_dOut;
  assign d_valid   = r_dValid;
  assign ext_ack   = r_extAck;
  assign ext_d_out = r_extDOut;
  assign busy      = (r_state == S_CLEAR);
  assign addr_err  = r_addrErr;

endmodule

// File: tb/tb_dmem_dp.sv
// Self-checking bench for dmem_dp: vector table, directed multi-cycle cases on a
// full-size and a 16-word instance, and randomized traffic against a memory model.
module tb_dmem_dp;

  localparam int DW     = 8;
  localparam int AW     = 19;
  localparam int DEPTH  = 67001;
  localparam int SDEPTH = 16;
  localparam logic [1:0] CI = 2'b00;
  localparam logic [1:0] CR = 2'b01;
  localparam logic [1:0] CW = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ext_we, ext_req, ext_ack, clr_start, busy, addr_err, d_valid;
  logic [AW-1:0] dAddr, extAddr;
  logic [DW-1:0] d_in, d_out, ext_d_in, ext_d_out;
  logic [1:0]    MEM_WRITE;

  logic          s_rst, s_ext_we, s_ext_req, s_ext_ack, s_clr_start, s_busy, s_addr_err, s_d_valid;
  logic [AW-1:0] s_dAddr, s_extAddr;
  logic [DW-1:0] s_d_in, s_d_out, s_ext_d_in, s_ext_d_out;
  logic [1:0]    s_MEM_WRITE;

  dmem_dp u_dut (
    .clk(clk), .rst(rst), .dAddr(dAddr), .d_in(d_in), .MEM_WRITE(MEM_WRITE),
    .d_out(d_out), .d_valid(d_valid), .extAddr(extAddr), .ext_d_in(ext_d_in),
    .ext_we(ext_we), .ext_req(ext_req), .ext_ack(ext_ack), .ext_d_out(ext_d_out),
    .clr_start(clr_start), .busy(busy), .addr_err(addr_err)
  );

  dmem_dp #(.DEPTH(SDEPTH)) u_small (
    .clk(clk), .rst(s_rst), .dAddr(s_dAddr), .d_in(s_d_in), .MEM_WRITE(s_MEM_WRITE),
    .d_out(s_d_out), .d_valid(s_d_valid), .extAddr(s_extAddr), .ext_d_in(s_ext_d_in),
    .ext_we(s_ext_we), .ext_req(s_ext_req), .ext_ack(s_ext_ack), .ext_d_out(s_ext_d_out),
    .clr_start(s_clr_start), .busy(s_busy), .addr_err(s_addr_err)
  );

  typedef struct {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] expDout;
    logic          expValid;
    logic          expErr;
  } vec_t;

  vec_t vecs [14];
  int nChecks = 0;
  int nErrors = 0;
  int busyCnt, ackEarly, waitCnt;

  logic [DW-1:0] mdl [int];
  logic [DW-1:0] expDout, expBOut;
  bit            dKnown, bKnown, expValid, expAck, expErr;
  bit            hReq;
  logic [AW-1:0] hAddr;
  logic          hWe;
  logic [DW-1:0] hData;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] cmd, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    MEM_WRITE = cmd;
    dAddr     = addr;
    d_in      = data;
  endtask

  task automatic sApply(input logic [1:0] cmd, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    s_MEM_WRITE = cmd;
    s_dAddr     = addr;
    s_d_in      = data;
  endtask

  function automatic logic [AW-1:0] pickAddr();
    int r;
    r = $urandom_range(0, 15);
    if (r <= 11) return AW'($urandom_range(0, 7));
    else if (r == 12) return AW'(DEPTH - 1);
    else if (r == 13) return AW'(DEPTH);
    else if (r == 14) return '1;
    return AW'(DEPTH - 2);
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; s_rst = 1'b1;
    applyStimulus(CI, '0, '0); sApply(CI, '0, '0);
    extAddr = '0; ext_d_in = '0; ext_we = 1'b0; ext_req = 1'b0; clr_start = 1'b0;
    s_extAddr = '0; s_ext_d_in = '0; s_ext_we = 1'b0; s_ext_req = 1'b0; s_clr_start = 1'b0;
    tick(); tick();
    rst = 1'b0; s_rst = 1'b0;

    checkOutput("rst_d_out", d_out, 0);
    checkOutput("rst_d_valid", d_valid, 0);
    checkOutput("rst_ext_ack", ext_ack, 0);
    checkOutput("rst_ext_d_out", ext_d_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_addr_err", addr_err, 0);
    checkOutput("rst_s_busy", s_busy, 0);

    // Port A table, including the last valid word and out-of-range accesses.
    vecs[0]  = '{CW, 19'd3,     8'hA5, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{CR, 19'd3,     8'h00, 8'hA5, 1'b1, 1'b0};
    vecs[2]  = '{CI, 19'd3,     8'h00, 8'hA5, 1'b0, 1'b0};
    vecs[3]  = '{CW, 19'd4,     8'h5A, 8'hA5, 1'b0, 1'b0};
    vecs[4]  = '{CR, 19'd4,     8'h00, 8'h5A, 1'b1, 1'b0};
    vecs[5]  = '{CR, 19'd3,     8'h00, 8'hA5, 1'b1, 1'b0};
    vecs[6]  = '{CW, 19'd67000, 8'hC3, 8'hA5, 1'b0, 1'b0};
    vecs[7]  = '{CR, 19'd67000, 8'h00, 8'hC3, 1'b1, 1'b0};
    vecs[8]  = '{CR, 19'd67001, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{CW, 19'd5,     8'h77, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{CR, 19'd5,     8'h00, 8'h77, 1'b1, 1'b1};
    vecs[11] = '{CW, 19'd67001, 8'hEE, 8'h77, 1'b0, 1'b1};
    vecs[12] = '{2'b11, 19'd3,  8'h99, 8'h77, 1'b0, 1'b1};
    vecs[13] = '{CR, 19'd3,     8'h00, 8'hA5, 1'b1, 1'b1};
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].addr, vecs[i].din);
      tick();
      checkOutput($sformatf("vec%0d_d_out", i), d_out, vecs[i].expDout);
      checkOutput($sformatf("vec%0d_d_valid", i), d_valid, vecs[i].expValid);
      checkOutput($sformatf("vec%0d_addr_err", i), addr_err, vecs[i].expErr);
    end
    applyStimulus(CI, '0, '0);
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("err_cleared", addr_err, 0);

    // Port B write then read back through both ports.
    extAddr = 19'd100; ext_d_in = 8'h3C; ext_we = 1'b1; ext_req = 1'b1;
    tick();
    checkOutput("b_wr_ack", ext_ack, 1);
    ext_req = 1'b0;
    tick();
    checkOutput("b_wr_ack_pulse", ext_ack, 0);
    applyStimulus(CR, 19'd100, '0);
    tick();
    checkOutput("a_rd_100", d_out, 8'h3C);
    applyStimulus(CI, '0, '0);
    ext_we = 1'b0; ext_req = 1'b1;
    tick();
    checkOutput("b_rd_ack", ext_ack, 1);
    checkOutput("b_rd_data", ext_d_out, 8'h3C);
    ext_req = 1'b0;
    tick();
    checkOutput("b_rd_ack_pulse", ext_ack, 0);
    checkOutput("b_rd_hold", ext_d_out, 8'h3C);

    // Same-address collision: A wins, B retries and overwrites.
    applyStimulus(CW, 19'd50, 8'h77);
    tick();
    applyStimulus(CW, 19'd50, 8'h11);
    extAddr = 19'd50; ext_d_in = 8'h22; ext_we = 1'b1; ext_req = 1'b1;
    tick();
    checkOutput("col_no_ack", ext_ack, 0);
    applyStimulus(CR, 19'd50, '0);
    tick();
    checkOutput("col_late_ack", ext_ack, 1);
    checkOutput("col_rd_first", d_out, 8'h11);
    ext_req = 1'b0;
    tick();
    checkOutput("col_final", d_out, 8'h22);
    checkOutput("col_ack_pulse", ext_ack, 0);

    // Different addresses both complete in the same cycle.
    applyStimulus(CW, 19'd60, 8'h01);
    extAddr = 19'd61; ext_d_in = 8'h02; ext_we = 1'b1; ext_req = 1'b1;
    tick();
    checkOutput("diff_ack", ext_ack, 1);
    ext_req = 1'b0;
    applyStimulus(CR, 19'd60, '0);
    tick();
    checkOutput("diff_a", d_out, 8'h01);
    applyStimulus(CR, 19'd61, '0);
    tick();
    checkOutput("diff_b", d_out, 8'h02);
    applyStimulus(CI, '0, '0);

    // Clear engine on the 16-word instance, with a port B read and a restart attempt mid-clear.
    for (int i = 0; i < SDEPTH; i++) begin
      sApply(CW, AW'(i), DW'(8'h40 + i));
      tick();
    end
    sApply(CI, '0, '0);
    s_clr_start = 1'b1;
    tick();
    s_clr_start = 1'b0;
    busyCnt = 0; ackEarly = 0;
    for (int c = 0; c < 40 && s_busy; c++) begin
      busyCnt++;
      if (s_ext_ack) ackEarly++;
      if (c == 3) begin s_extAddr = 19'd5; s_ext_we = 1'b0; s_ext_req = 1'b1; end
      s_clr_start = (c == 5);
      sApply((c == 8) ? CW : CI, 19'd9, 8'hDD);
      tick();
    end
    s_clr_start = 1'b0;
    sApply(CI, '0, '0);
    checkOutput("clr_busy_cycles", busyCnt, SDEPTH);
    checkOutput("clr_no_ack_busy", ackEarly, 0);
    waitCnt = 0;
    for (int w = 0; w < 5 && !s_ext_ack; w++) begin
      waitCnt++;
      tick();
    end
    checkOutput("clr_b_ack", s_ext_ack, 1);
    checkOutput("clr_b_wait", waitCnt, 1);
    checkOutput("clr_b_data", s_ext_d_out, 0);
    s_ext_req = 1'b0;
    for (int i = 0; i < SDEPTH; i++) begin
      sApply(CR, AW'(i), '0);
      tick();
      checkOutput($sformatf("clr_word%0d", i), s_d_out, 0);
    end
    sApply(CI, '0, '0);

    // Reset arriving while the pointer is at word 7.
    for (int i = 0; i < SDEPTH; i++) begin
      sApply(CW, AW'(i), DW'(8'h80 + i));
      tick();
    end
    sApply(CI, '0, '0);
    s_clr_start = 1'b1;
    tick();
    s_clr_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    checkOutput("mid_rst_busy", s_busy, 0);
    tick();
    checkOutput("mid_rst_idle", s_busy, 0);
    for (int i = 0; i < 9; i++) begin
      if (i == 7) continue;
      sApply(CR, AW'(i), '0);
      tick();
      checkOutput($sformatf("mid_rst_word%0d", i), s_d_out, (i < 7) ? 0 : 8'h88);
    end
    sApply(CI, '0, '0);
    s_rst = 1'b1; s_clr_start = 1'b1;
    tick();
    s_rst = 1'b0; s_clr_start = 1'b0;
    checkOutput("rst_beats_clr", s_busy, 0);
    tick();
    checkOutput("rst_beats_clr2", s_busy, 0);

    // Randomized traffic on the full-size instance against an address-keyed model.
    rst = 1'b1; tick(); rst = 1'b0;
    mdl.delete();
    expDout = '0; expBOut = '0; dKnown = 1; bKnown = 1;
    expValid = 0; expAck = 0; expErr = 0; hReq = 0; hAddr = '0; hWe = 0; hData = '0;
    for (int n = 0; n < 500; n++) begin
      logic [1:0]    cmd;
      logic [AW-1:0] aAddr;
      logic [DW-1:0] aData;
      bit            aWr, aRd, aOor, bOor, bAcc;
      case ($urandom_range(0, 3))
        0: cmd = CW;
        1: cmd = CR;
        2: cmd = CI;
        default: cmd = 2'b11;
      endcase
      aAddr = pickAddr();
      aData = DW'($urandom);
      if (expAck) hReq = 0;
      else if (!hReq && $urandom_range(0, 1) == 1) begin
        hReq = 1; hAddr = pickAddr(); hWe = $urandom_range(0, 1) == 1; hData = DW'($urandom);
      end
      applyStimulus(cmd, aAddr, aData);
      extAddr = hAddr; ext_we = hWe; ext_d_in = hData; ext_req = hReq;

      aWr  = (cmd == CW);
      aRd  = (cmd == CR);
      aOor = (int'(aAddr) >= DEPTH);
      bOor = (int'(hAddr) >= DEPTH);
      bAcc = hReq && !expAck && !(hWe && aWr && aAddr == hAddr);
      expValid = aRd;
      if (aRd) begin
        if (aOor) begin expDout = '0; dKnown = 1; end
        else if (mdl.exists(int'(aAddr))) begin expDout = mdl[int'(aAddr)]; dKnown = 1; end
        else dKnown = 0;
      end
      if (bAcc && !hWe) begin
        if (bOor) begin expBOut = '0; bKnown = 1; end
        else if (mdl.exists(int'(hAddr))) begin expBOut = mdl[int'(hAddr)]; bKnown = 1; end
        else bKnown = 0;
      end
      if (((aWr || aRd) && aOor) || (bAcc && bOor)) expErr = 1;
      if (aWr && !aOor) mdl[int'(aAddr)] = aData;
      if (bAcc && hWe && !bOor) mdl[int'(hAddr)] = hData;
      expAck = bAcc;

      tick();
      checkOutput("rnd_d_valid", d_valid, expValid);
      checkOutput("rnd_ext_ack", ext_ack, expAck);
      checkOutput("rnd_addr_err", addr_err, expErr);
      if (dKnown) checkOutput("rnd_d_out", d_out, expDout);
      if (bKnown) checkOutput("rnd_ext_d_out", ext_d_out, expBOut);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
